// File: rtl/game_ctrl.sv
// Pong-style match controller: sequences IDLE/SERVE/PLAY/POINT/OVER, keeps scores and picks the winner.
// Define GAME_CTRL_WIN_BY_TWO_EN to require a two-point lead to win (deuce folds back to WIN_SCORE-1).
module game_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int SCREEN_WIDTH = 640,
  parameter int BALL_SIZE    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic       ball_load,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] POINT = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam int              CNT_W      = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES);
  localparam logic [4:0]      WIN5       = 5'(WIN_SCORE);
  localparam logic [3:0]      WIN4       = 4'(WIN_SCORE);
  localparam logic [9:0]      RIGHT_EDGE = 10'(SCREEN_WIDTH - BALL_SIZE);

  logic             start_q;
  logic             armed;
  logic             start_rise;
  logic [CNT_W-1:0] serve_cnt;
  logic [CNT_W-1:0] serve_cnt_inc;
  logic             point_won;
  logic             last_p1;

  logic       point_hit;
  logic       p1_scores;
  logic [4:0] s1_next;
  logic [4:0] s2_next;
  logic [4:0] scorer_new;
  logic [4:0] other_new;
  logic       won;
  logic [3:0] s1_sat;
  logic [3:0] s2_sat;

  // armed stays low until start is seen low, so a button held through reset release cannot start a game
  assign start_rise    = start && !start_q && armed;
  assign serve_cnt_inc = serve_cnt + CNT_W'(1);
  assign ball_run      = (state == PLAY);

  assign point_hit = frame_tick && ((ball_x == 10'd0) || (ball_x >= RIGHT_EDGE));
  assign p1_scores = (ball_x != 10'd0);

  // Score arithmetic is one bit wider so a point past WIN_SCORE can still be judged before saturating
  always_comb begin
    s1_next    = {1'b0, score1} + {4'd0, p1_scores};
    s2_next    = {1'b0, score2} + {4'd0, !p1_scores};
    scorer_new = p1_scores ? s1_next : s2_next;
    other_new  = p1_scores ? s2_next : s1_next;
    s1_sat     = (s1_next > WIN5) ? WIN4 : s1_next[3:0];
    s2_sat     = (s2_next > WIN5) ? WIN4 : s2_next[3:0];
`ifdef GAME_CTRL_WIN_BY_TWO_EN
    won = (scorer_new >= WIN5) && (scorer_new >= other_new + 5'd2);
    if ((s1_next == WIN5) && (s2_next == WIN5)) begin
      s1_sat = WIN4 - 4'd1;
      s2_sat = WIN4 - 4'd1;
    end
`else
    won = (scorer_new >= WIN5);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      score1    <= 4'd0;
      score2    <= 4'd0;
      winner    <= 2'b00;
      ball_load <= 1'b0;
      serve_dir <= 1'b1;
      serve_cnt <= '0;
      start_q   <= 1'b0;
      armed     <= 1'b0;
      point_won <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      start_q   <= start;
      ball_load <= 1'b0;
      if (!start) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_rise) begin
            state     <= SERVE;
            ball_load <= 1'b1;
            serve_cnt <= '0;
            serve_dir <= 1'b1;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            serve_cnt <= serve_cnt_inc;
            if (serve_cnt_inc == SERVE_LAST) begin
              state <= PLAY;
            end
          end
        end
        PLAY: begin
          if (point_hit) begin
            state     <= POINT;
            score1    <= s1_sat;
            score2    <= s2_sat;
            point_won <= won;
            last_p1   <= p1_scores;
          end
        end
        // The serve goes away from whoever just scored
        POINT: begin
          if (point_won) begin
            state  <= OVER;
            winner <= last_p1 ? 2'b01 : 2'b10;
          end else begin
            state     <= SERVE;
            ball_load <= 1'b1;
            serve_cnt <= '0;
            serve_dir <= last_p1;
          end
        end
        OVER: begin
          if (start_rise) begin
            state  <= IDLE;
            score1 <= 4'd0;
            score2 <= 4'd0;
            winner <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 11, points needed to win (2..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frame_tick count spent in SERVE before play (>=1).
REQ-003 Parameter SCREEN_WIDTH, default 640, playfield width in pixels.
REQ-004 Parameter BALL_SIZE, default 4, ball edge length in pixels.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 start  input  1  synchronised start button, level.
REQ-009 ball_x  input  10  current ball left-edge x position.
REQ-010 ball_load  output  1  one-cycle pulse: ball recentres, takes serve_dir.
REQ-011 ball_run  output  1  ball may advance while high.
REQ-012 serve_dir  output  1  1 = serve toward right (player 2), 0 = toward left (player 1).
REQ-013 score1, score2  output  4 each  player scores.
REQ-014 winner  output  2  00 none, 01 player 1, 10 player 2.
REQ-015 state  output  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Function
REQ-016 The block SHALL register start and treat start_rise as start high while the registered value was low.
REQ-017 IDLE: ball_run=0, scores 0, winner 00; start_rise SHALL move to SERVE, pulse ball_load and clear the serve counter in the same edge.
REQ-018 SERVE: ball_run=0; counter SHALL increment on each frame_tick; the edge on which counter reaches SERVE_FRAMES SHALL enter PLAY with ball_run=1.
REQ-019 PLAY: on an edge with frame_tick=1, ball_x==0 SHALL increment score2; ball_x>=SCREEN_WIDTH-BALL_SIZE SHALL increment score1; either SHALL enter POINT with ball_run=0 on that edge.
REQ-020 PLAY: no frame_tick, or ball_x between bounds, SHALL hold state; scoring latency is exactly one clock after the frame_tick cycle.
REQ-021 POINT SHALL last exactly one cycle, ignoring frame_tick and start.
REQ-022 POINT exit: if scorer's score>=WIN_SCORE and win condition (REQ-033) met, go to OVER and set winner; else go to SERVE, pulse ball_load, clear counter.
REQ-023 serve_dir SHALL be 1 after reset and on IDLE->SERVE; on POINT->SERVE it SHALL point away from the scorer (player 1 scored -> 1, player 2 scored -> 0).
REQ-024 OVER: ball_run=0, scores and winner held; start_rise SHALL enter IDLE, clearing scores and winner.
REQ-025 start_rise in SERVE, PLAY or POINT SHALL be ignored.
REQ-026 ball_load SHALL never be high for two consecutive cycles; ball_run and ball_load SHALL never be high together.
REQ-027 Scores SHALL never exceed WIN_SCORE.

Reset
REQ-028 reset SHALL force state=IDLE, score1=score2=0, winner=00, ball_load=0, ball_run=0, serve_dir=1, serve counter=0, registered start=0.
REQ-029 reset asserted mid-rally SHALL take effect asynchronously; release SHALL resume from IDLE only.
REQ-030 A start held high through reset release SHALL NOT produce start_rise.

Configuration
REQ-031 Macro GAME_CTRL_WIN_BY_TWO_EN SHALL select the win rule.
REQ-032 Without it: first player reaching WIN_SCORE wins.
REQ-033 With it: win requires score>=WIN_SCORE and lead>=2; a point leaving both scores at WIN_SCORE SHALL set both to WIN_SCORE-1 on the same edge.

Verification
REQ-034 reset, start pulse, SERVE_FRAMES=3 -> ball_load one cycle, ball_run rises on edge of third frame_tick, serve_dir=1.
REQ-035 PLAY, frame_tick with ball_x=636 -> next edge score1=1, state=POINT, then SERVE, ball_load pulse, serve_dir=1.
REQ-036 PLAY, ball_x=0 without frame_tick -> no change; with frame_tick -> score2 increments, serve_dir=0.
REQ-037 WIN_SCORE=3, player 1 scores 3 -> state=OVER, winner=01; start_rise -> IDLE, scores 0.
REQ-038 WIN_BY_TWO_EN, WIN_SCORE=3, scores 2-2, then P1, P2 -> scores 2-2; then P1, P1 -> winner=01, score1=3... within bounds.
REQ-039 reset asserted during PLAY with score 5-4 -> immediately IDLE, scores 0, ball_run=0.
